trap_sequencer: RTL and testbench

Multi-cycle controller that sequences machine-mode interrupt entry and `mret` return for the 5-stage RISC-V pipeline. It watches the EX and MEM stages and the interrupt lines, and arbitrates between a pending interrupt and an `mret` in flight. It then drives a one-cycle flush/redirect to the fetch unit and one-cycle commit strobes to the CSR file. It sits between the hazard/flush logic, the PC mux and the CSR file, and consumes the decoder's `is_mret`, pipelined to MEM.

---
 rtl/trap_sequencer.sv | 124 ++++++++++++
 tb/tb_trap_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry / mret return sequencer for the 5-stage pipeline.
// Issues a one-cycle flush/redirect plus CSR commit strobe, then blocks new events for GAP cycles.
module trap_sequencer #(
    parameter int DW  = 32,
    parameter int GAP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_valid_e,
    input  logic [DW-1:0] pc_e,
    input  logic          inst_valid_m,
    input  logic          is_mret_m,
    input  logic          timer_irq,
    input  logic          ext_irq,
    input  logic          mie_global,
    input  logic          mie_mtie,
    input  logic          mie_meie,
    input  logic [DW-1:0] mtvec,
    input  logic [DW-1:0] mepc,
    output logic          flush,
    output logic          pc_redirect,
    output logic [DW-1:0] pc_target,
    output logic          trap_taken,
    output logic [DW-1:0] trap_mepc,
    output logic [DW-1:0] trap_mcause,
    output logic          mret_taken,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        RETURN = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [DW-1:0] ALIGN_MASK = {{(DW-2){1'b1}}, 2'b00};

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic          latch_mret;
    logic          latch_trap;
    logic          irq_ok;
    logic          ext_sel;
    logic [DW-1:0] code;
    logic [DW-1:0] base;
    logic [DW-1:0] vec_target;

    assign irq_ok  = mie_global & ((ext_irq & mie_meie) | (timer_irq & mie_mtie));
    assign ext_sel = ext_irq & mie_meie;
    assign code    = ext_sel ? DW'(11) : DW'(7);
    assign base    = mtvec & ALIGN_MASK;
    // Vectored mode: each cause gets its own 4-byte slot above the base.
    assign vec_target = (mtvec[1:0] == 2'b01) ? base + (code << 2) : base;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        latch_mret  = 1'b0;
        latch_trap  = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        trap_taken  = 1'b0;
        mret_taken  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                // mret outranks an interrupt; the interrupt is retried after WAIT.
                if (inst_valid_m && is_mret_m) begin
                    latch_mret = 1'b1;
                    state_nxt  = RETURN;
                end else if (irq_ok && inst_valid_e) begin
                    latch_trap = 1'b1;
                    state_nxt  = ENTER;
                end
            end
            ENTER: begin
                trap_taken  = 1'b1;
                flush       = 1'b1;
                pc_redirect = 1'b1;
                state_nxt   = WAIT;
                cnt_nxt     = 4'(GAP - 1);
            end
            RETURN: begin
                mret_taken  = 1'b1;
                flush       = 1'b1;
                pc_redirect = 1'b1;
                state_nxt   = WAIT;
                cnt_nxt     = 4'(GAP - 1);
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            pc_target   <= '0;
            trap_mepc   <= '0;
            trap_mcause <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch_mret) begin
                pc_target <= mepc & ALIGN_MASK;
            end else if (latch_trap) begin
                pc_target   <= vec_target;
                trap_mepc   <= pc_e;
                trap_mcause <= {1'b1, code[DW-2:0]};
            end
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed vectors, a timeline model of event windows,
// and per-cycle comparison of every output against that model.
module tb_trap_sequencer;

    localparam int DW  = 32;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_valid_e;
    logic [DW-1:0] pc_e;
    logic          inst_valid_m;
    logic          is_mret_m;
    logic          timer_irq;
    logic          ext_irq;
    logic          mie_global;
    logic          mie_mtie;
    logic          mie_meie;
    logic [DW-1:0] mtvec;
    logic [DW-1:0] mepc;
    logic          flush;
    logic          pc_redirect;
    logic [DW-1:0] pc_target;
    logic          trap_taken;
    logic [DW-1:0] trap_mepc;
    logic [DW-1:0] trap_mcause;
    logic          mret_taken;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    trap_sequencer #(.DW(DW), .GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_e(inst_valid_e), .pc_e(pc_e),
        .inst_valid_m(inst_valid_m), .is_mret_m(is_mret_m),
        .timer_irq(timer_irq), .ext_irq(ext_irq),
        .mie_global(mie_global), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
        .mtvec(mtvec), .mepc(mepc),
        .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .trap_taken(trap_taken), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
        .mret_taken(mret_taken), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted event at edge e gives a strobe in the period
    // after edge e, busy for periods e..e+GAP, and the next decision at edge e+GAP+2.
    int            edge_no  = 0;
    int            free_at  = 0;
    bit            has_ev   = 0;
    bit            ev_trap  = 0;
    int            ev_edge  = 0;
    bit            chk_en   = 0;
    logic [DW-1:0] m_target = '0;
    logic [DW-1:0] m_mepc   = '0;
    logic [DW-1:0] m_mcause = '0;

    always @(posedge clk) begin
        int unsigned code;
        edge_no++;
        if (rst) begin
            has_ev   = 0;
            m_target = '0;
            m_mepc   = '0;
            m_mcause = '0;
            free_at  = edge_no + 1;
            chk_en   = 1;
        end else if (edge_no >= free_at) begin
            if (inst_valid_m && is_mret_m) begin
                has_ev   = 1;
                ev_trap  = 0;
                ev_edge  = edge_no;
                m_target = (mepc / 4) * 4;
                free_at  = edge_no + GAP + 2;
            end else if (mie_global && inst_valid_e &&
                         ((ext_irq && mie_meie) || (timer_irq && mie_mtie))) begin
                code     = (ext_irq && mie_meie) ? 11 : 7;
                has_ev   = 1;
                ev_trap  = 1;
                ev_edge  = edge_no;
                m_mepc   = pc_e;
                m_mcause = 32'h8000_0000 + code;
                m_target = (mtvec / 4) * 4;
                if (mtvec % 4 == 1) m_target = m_target + 4 * code;
                free_at  = edge_no + GAP + 2;
            end
        end
    end

    always @(negedge clk) begin
        bit strobe;
        bit exp_busy;
        if (chk_en) begin
            strobe   = has_ev && (edge_no == ev_edge);
            exp_busy = has_ev && (edge_no >= ev_edge) && (edge_no <= ev_edge + GAP);
            chk("flush",       DW'(flush),       DW'(strobe));
            chk("pc_redirect", DW'(pc_redirect), DW'(strobe));
            chk("trap_taken",  DW'(trap_taken),  DW'(strobe && ev_trap));
            chk("mret_taken",  DW'(mret_taken),  DW'(strobe && !ev_trap));
            chk("busy",        DW'(busy),        DW'(exp_busy));
            chk("pc_target",   pc_target,        m_target);
            chk("trap_mepc",   trap_mepc,        m_mepc);
            chk("trap_mcause", trap_mcause,      m_mcause);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic quiet_inputs();
        inst_valid_e = 1'b0; pc_e = '0; inst_valid_m = 1'b0; is_mret_m = 1'b0;
        timer_irq = 1'b0; ext_irq = 1'b0; mie_global = 1'b0;
        mie_mtie = 1'b0; mie_meie = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mtvec = '0;
        mepc  = '0;
        quiet_inputs();
        step(3);
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_busy", DW'(busy), '0);
            chk("idle_flush", DW'(flush), '0);
        end
        chk("idle_target", pc_target, '0);

        // Timer trap, direct mode
        mtvec = 32'h0000_0100; pc_e = 32'h0000_0040; inst_valid_e = 1'b1;
        mie_global = 1'b1; mie_mtie = 1'b1; timer_irq = 1'b1;
        step();
        chk("tmr_trap_taken", DW'(trap_taken), 1);
        chk("tmr_target", pc_target, 32'h0000_0100);
        chk("tmr_mepc", trap_mepc, 32'h0000_0040);
        chk("tmr_mcause", trap_mcause, 32'h8000_0007);
        mie_global = 1'b0; timer_irq = 1'b0;
        step();
        chk("tmr_wait1_busy", DW'(busy), 1);
        step();
        chk("tmr_wait2_busy", DW'(busy), 1);
        step();
        chk("tmr_done_busy", DW'(busy), 0);

        // Vectored external trap with both lines pending
        mtvec = 32'h0000_0201; pc_e = 32'h0000_0080;
        mie_global = 1'b1; mie_mtie = 1'b1; mie_meie = 1'b1;
        timer_irq = 1'b1; ext_irq = 1'b1;
        step();
        chk("vec_trap_taken", DW'(trap_taken), 1);
        chk("vec_mcause", trap_mcause, 32'h8000_000B);
        chk("vec_target", pc_target, 32'h0000_022C);
        chk("vec_mepc", trap_mepc, 32'h0000_0080);
        mie_global = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0; mie_meie = 1'b0;
        step(3);

        // mret together with an enabled timer interrupt
        mepc = 32'h0000_0044; pc_e = 32'h0000_0090; mtvec = 32'h0000_0100;
        mie_global = 1'b1; mie_mtie = 1'b1; timer_irq = 1'b1;
        inst_valid_m = 1'b1; is_mret_m = 1'b1;
        step();
        chk("mret_taken", DW'(mret_taken), 1);
        chk("mret_no_trap", DW'(trap_taken), 0);
        chk("mret_target", pc_target, 32'h0000_0044);
        inst_valid_m = 1'b0; is_mret_m = 1'b0;
        step(3);
        chk("mret_gap_idle", DW'(busy), 0);
        step();
        chk("mret_then_trap", DW'(trap_taken), 1);
        chk("mret_then_mepc", trap_mepc, 32'h0000_0090);
        mie_global = 1'b0; timer_irq = 1'b0;
        step(3);

        // Misaligned mepc is forced to a word boundary
        mepc = 32'h0000_0047; inst_valid_m = 1'b1; is_mret_m = 1'b1;
        step();
        chk("mret_align", pc_target, 32'h0000_0044);
        inst_valid_m = 1'b0; is_mret_m = 1'b0;
        step(3);

        // Global mask
        timer_irq = 1'b1; ext_irq = 1'b1; mie_mtie = 1'b1; mie_meie = 1'b1;
        inst_valid_e = 1'b1; mie_global = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mask_no_trap", DW'(trap_taken), 0);
        end
        ext_irq = 1'b0; mie_meie = 1'b0;

        // Bubble in EX defers the trap
        pc_e = 32'h0000_00C0; inst_valid_e = 1'b0; mie_global = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bubble_no_trap", DW'(trap_taken), 0);
        end
        inst_valid_e = 1'b1;
        step();
        chk("bubble_trap", DW'(trap_taken), 1);
        chk("bubble_mepc", trap_mepc, 32'h0000_00C0);
        mie_global = 1'b0; timer_irq = 1'b0;
        step(3);

        // Reset in the ENTER cycle
        pc_e = 32'h0000_0100; mie_global = 1'b1; timer_irq = 1'b1;
        step();
        chk("rst_enter", DW'(trap_taken), 1);
        rst = 1'b1; mie_global = 1'b0; timer_irq = 1'b0;
        step();
        rst = 1'b0;
        chk("rst_no_strobe", DW'(trap_taken | flush | pc_redirect), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_target", pc_target, '0);
        chk("rst_mcause", trap_mcause, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_quiet", DW'(flush | busy), 0);
        end

        quiet_inputs();
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
